slt_iter: RTL

Parametrised, multi-cycle set-less-than unit, signed or unsigned, and the successor to the fixed 32-bit combinational SLTU. It compares two WIDTH-bit operands CHUNK bits per cycle, starting at the most-significant chunk, and exits early on the first differing chunk. It sits beside the ALU in the multi-cycle datapath and serves SLT, SLTU, SLTI and SLTIU through a start/done handshake. Its result format matches the existing SLTU: rd is zero-extended 0/1 and overflow is always 0.

---
 rtl/slt_iter.sv | 118 +++++++++++
 1 files changed

// File: rtl/slt_iter.sv
// Multi-cycle set-less-than (signed/unsigned), comparing CHUNK bits per cycle from the MSB chunk down.
// Latency: 1..N cycles from accept to done, exiting on the first differing chunk; N for equal operands.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
module slt_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] rd,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMP,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] rt_q, rt_d;
    logic             sgn_q, sgn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] rs_chunk;
    logic [CHUNK-1:0] rt_chunk;

    // Chunk mux; flipping the sign bit of the top chunk turns a signed compare into an unsigned one.
    always_comb begin
        rs_chunk = '0;
        rt_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rs_chunk = rs_q[WIDTH-1-i*CHUNK -: CHUNK];
                rt_chunk = rt_q[WIDTH-1-i*CHUNK -: CHUNK];
            end
        end
        if (sgn_q && (idx_q == '0)) begin
            rs_chunk[CHUNK-1] = ~rs_chunk[CHUNK-1];
            rt_chunk[CHUNK-1] = ~rt_chunk[CHUNK-1];
        end
    end

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        ovf_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rs_d    = rs;
                    rt_d    = rt;
                    sgn_d   = is_signed;
                    idx_d   = '0;
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (rs_chunk != rt_chunk) begin
                    lt_d    = (rs_chunk < rt_chunk);
                    state_d = ST_DONE;
                end else if (idx_q == IDX_LAST) begin
                    lt_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rs_q    <= '0;
            rt_q    <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rd       = WIDTH'(lt_q);
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_CMP);
    assign done     = (state_q == ST_DONE);

endmodule
